// File: rtl/cnt_pkg.sv
// Shared types and constants for the loadable down counter family.
package cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/down_cnt_reload.sv
// Loadable down counter with reload register, terminal-count pulse and
// borrow chain for cascading identical stages.
//
// state | meaning
// IDLE  | after reset; q holds, en ignored
// RUN   | counting on each qualified step (en & bi)
// DONE  | one-shot expired; q holds at 0 until load or mr
module down_cnt_reload
  import cnt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             load,
  input  logic             en,
  input  logic             bi,
  input  logic             mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             bo,
  output logic             tc,
  output logic             busy
);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] rl, rl_d;
  logic [WIDTH-1:0] q_d;
  logic             tc_d;
  logic             step;
  logic             at_zero;

  assign step    = en & bi;
  assign at_zero = (q == '0);

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      state_q <= IDLE;
      q       <= '0;
      rl      <= '0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      q       <= q_d;
      rl      <= rl_d;
      tc      <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q;
    rl_d    = rl;
    tc_d    = 1'b0;
    if (!load) begin
      q_d     = d;
      rl_d    = d;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (step) begin
            if (!at_zero) begin
              q_d = q - WIDTH'(1);
            end else begin
              // Expiry: reload keeps running, one-shot parks at zero.
              tc_d = 1'b1;
              if (mode == MODE_RELOAD) q_d = rl;
              else                     state_d = DONE;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign bo   = (state_q == RUN) & step & at_zero;

endmodule

// File: tb/tb_down_cnt_reload.sv
// Directed self-checking bench for down_cnt_reload, including a 16-bit
// two-stage cascade.
module tb_down_cnt_reload;

  logic       clk = 1'b0;
  logic       mr, load, en, bi, mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       bo, tc, busy;

  logic       load_hi, mode_hi;
  logic [7:0] d_hi;
  logic [7:0] q_hi;
  logic       bo_hi, tc_hi, busy_hi;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  down_cnt_reload #(.WIDTH(8)) dut (
    .clk(clk), .mr(mr), .load(load), .en(en), .bi(bi), .mode(mode),
    .d(d), .q(q), .bo(bo), .tc(tc), .busy(busy)
  );

  down_cnt_reload #(.WIDTH(8)) dut_hi (
    .clk(clk), .mr(mr), .load(load_hi), .en(en), .bi(bo), .mode(mode_hi),
    .d(d_hi), .q(q_hi), .bo(bo_hi), .tc(tc_hi), .busy(busy_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mr = 1'b0; load = 1'b0; en = 1'b1; bi = 1'b1; mode = 1'b0; d = 8'hAA;
    load_hi = 1'b1; mode_hi = 1'b0; d_hi = 8'h00;
    for (int i = 0; i < 10; i++) begin
      #10;
      checks++;
      if (q !== 8'h00 || tc !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold t=%0t q=%h tc=%b busy=%b expected q=00 tc=0 busy=0",
                 $time, q, tc, busy);
      end
    end
    load = 1'b1; en = 1'b1;
    @(negedge clk);
    mr = 1'b1;
    tick();
    // IDLE ignores en after release
    checks++;
    if (q !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release q=%h busy=%b expected q=00 busy=0", q, busy);
    end
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_q [4] = '{8'h02, 8'h01, 8'h00, 8'h00};
    mode = 1'b0; en = 1'b1; bi = 1'b1;
    load = 1'b0; d = 8'h03;
    tick();
    load = 1'b1;
    checks++;
    if (q !== 8'h03 || tc !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_load q=%h tc=%b busy=%b expected q=03 tc=0 busy=1", q, tc, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || tc !== (i == 3) || busy !== (i != 3)) begin
        failures++;
        $display("FAIL oneshot_step%0d q=%h tc=%b busy=%b expected q=%h tc=%b busy=%b",
                 i + 1, q, tc, busy, exp_q[i], (i == 3), (i != 3));
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 8'h00 || tc !== 1'b0 || busy !== 1'b0 || bo !== 1'b0) begin
        failures++;
        $display("FAIL oneshot_done q=%h tc=%b busy=%b bo=%b expected q=00 tc=0 busy=0 bo=0",
                 q, tc, busy, bo);
      end
    end
    load = 1'b0; d = 8'h07;
    tick();
    load = 1'b1;
    checks++;
    if (q !== 8'h07 || busy !== 1'b1 || tc !== 1'b0) begin
      failures++;
      $display("FAIL load_from_done q=%h busy=%b tc=%b expected q=07 busy=1 tc=0", q, busy, tc);
    end
  endtask

  task automatic test_reload();
    logic [7:0] eq;
    mode = 1'b1; en = 1'b1; bi = 1'b1;
    load = 1'b0; d = 8'h02;
    tick();
    load = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      eq = (k % 3 == 1) ? 8'h01 : (k % 3 == 2) ? 8'h00 : 8'h02;
      checks++;
      if (q !== eq || tc !== (k % 3 == 0) || busy !== 1'b1) begin
        failures++;
        $display("FAIL reload_step%0d q=%h tc=%b busy=%b expected q=%h tc=%b busy=1",
                 k, q, tc, busy, eq, (k % 3 == 0));
      end
    end
  endtask

  task automatic test_gating();
    mode = 1'b0; bi = 1'b1; en = 1'b1;
    load = 1'b0; d = 8'h05;
    tick();
    load = 1'b1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== 8'h05 || tc !== 1'b0) begin
        failures++;
        $display("FAIL gate_en q=%h tc=%b expected q=05 tc=0", q, tc);
      end
    end
    en = 1'b1; bi = 1'b0;
    tick();
    checks++;
    if (q !== 8'h05 || tc !== 1'b0 || bo !== 1'b0) begin
      failures++;
      $display("FAIL gate_bi q=%h tc=%b bo=%b expected q=05 tc=0 bo=0", q, tc, bo);
    end
    bi = 1'b1;
    tick();
    checks++;
    if (q !== 8'h04 || bo !== 1'b0) begin
      failures++;
      $display("FAIL gate_step q=%h bo=%b expected q=04 bo=0", q, bo);
    end
    load = 1'b0; d = 8'h00;
    tick();
    load = 1'b1; en = 1'b1; bi = 1'b1;
    #1;
    checks++;
    if (bo !== 1'b1) begin
      failures++;
      $display("FAIL bo_active bo=%b expected 1", bo);
    end
    bi = 1'b0;
    #1;
    checks++;
    if (bo !== 1'b0) begin
      failures++;
      $display("FAIL bo_bi_low bo=%b expected 0", bo);
    end
    bi = 1'b1; en = 1'b0;
    #1;
    checks++;
    if (bo !== 1'b0) begin
      failures++;
      $display("FAIL bo_en_low bo=%b expected 0", bo);
    end
    en = 1'b1;
    tick();
    // loaded zero expires on the first qualified step
    checks++;
    if (tc !== 1'b1 || busy !== 1'b0 || q !== 8'h00) begin
      failures++;
      $display("FAIL zero_expire tc=%b busy=%b q=%h expected tc=1 busy=0 q=00", tc, busy, q);
    end
  endtask

  task automatic test_load_priority();
    mode = 1'b0; en = 1'b1; bi = 1'b1;
    load = 1'b0; d = 8'h01;
    tick();
    load = 1'b1;
    tick();
    checks++;
    if (q !== 8'h00 || busy !== 1'b1 || bo !== 1'b1) begin
      failures++;
      $display("FAIL prio_setup q=%h busy=%b bo=%b expected q=00 busy=1 bo=1", q, busy, bo);
    end
    load = 1'b0; d = 8'hEE;
    tick();
    load = 1'b1;
    checks++;
    if (q !== 8'hEE || tc !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL prio_load q=%h tc=%b busy=%b expected q=ee tc=0 busy=1", q, tc, busy);
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; en = 1'b1; bi = 1'b1;
    load = 1'b0; d = 8'h50;
    tick();
    load = 1'b1;
    tick();
    tick();
    #2;
    mr = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || tc !== 1'b0) begin
      failures++;
      $display("FAIL async_reset q=%h busy=%b tc=%b expected q=00 busy=0 tc=0", q, busy, tc);
    end
    @(negedge clk);
    mr = 1'b1;
    tick();
    checks++;
    if (q !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_release q=%h busy=%b expected q=00 busy=0", q, busy);
    end
  endtask

  task automatic test_cascade();
    int n;
    int tc_at;
    tc_at = -1;
    en = 1'b0; bi = 1'b1;
    mode = 1'b1; d = 8'hFF; load = 1'b0;
    mode_hi = 1'b0; d_hi = 8'h01; load_hi = 1'b0;
    tick();
    load = 1'b1; load_hi = 1'b1; en = 1'b1;
    for (n = 1; n <= 600 && tc_at < 0; n++) begin
      tick();
      if (n == 255) begin
        checks++;
        if (q_hi !== 8'h01 || q !== 8'h00) begin
          failures++;
          $display("FAIL cascade_pre_wrap q_hi=%h q=%h expected q_hi=01 q=00", q_hi, q);
        end
      end
      if (n == 256) begin
        checks++;
        if (q_hi !== 8'h00 || q !== 8'hFF) begin
          failures++;
          $display("FAIL cascade_wrap1 q_hi=%h q=%h expected q_hi=00 q=ff", q_hi, q);
        end
      end
      if (tc_hi === 1'b1) tc_at = n;
    end
    checks++;
    if (tc_at != 512) begin
      failures++;
      $display("FAIL cascade_tc step=%0d expected 512 (-1 means timeout)", tc_at);
    end
    checks++;
    if (busy_hi !== 1'b0) begin
      failures++;
      $display("FAIL cascade_done busy_hi=%b expected 0", busy_hi);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_gating();
    test_load_priority();
    test_async_reset();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
